// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, reads the combinational
// instruction memory, and buffers {pc, instr} pairs in a small in-order
// queue for decode. Redirects from execute flush the queue. A misaligned
// redirect target latches a sticky fault that stops fetch until reset.
//
// Handshake to decode (valid/ready): out_valid/out_instr/out_pc/out_pc_plus4
// describe the head entry. A transfer happens on a rising edge where
// out_valid & out_ready. While out_valid & ~out_ready the head is held
// stable. out_valid never depends combinationally on out_ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        fetch_fault
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic          fault_q;
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic head_valid;
  logic pop;
  logic push;
  logic misaligned;

  assign head_valid = (count != '0) & ~fault_q;
  assign pop        = head_valid & out_ready;
  // A full queue can still accept a word when the head leaves the same cycle.
  assign push       = ~redirect & ~fault_q & ((count < FULL) | pop);
  assign misaligned = redirect & (redirect_pc[1:0] != 2'b00);

  assign imem_addr    = fetch_pc;
  assign out_valid    = head_valid;
  assign fetch_fault  = fault_q;
  assign out_pc       = head_valid ? pc_q[rd_ptr] : 32'h0;
  assign out_instr    = head_valid ? instr_q[rd_ptr] : 32'h0;
  assign out_pc_plus4 = head_valid ? (pc_q[rd_ptr] + 32'd4) : 32'h0;

  // Control state: fetch PC, pointers, occupancy and the sticky fault.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      fault_q  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      // Redirect wins over push/pop; any head popped now is simply dropped
      // along with the rest of the queue.
      fetch_pc <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      if (misaligned) fault_q <= 1'b1;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage: capture {fetch_pc, imem_rdata} at the write pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= 32'h0;
        instr_q[i] <= 32'h0;
      end
    end else if (push) begin
      pc_q[wr_ptr]    <= fetch_pc;
      instr_q[wr_ptr] <= imem_rdata;
    end
  end

endmodule
